// File: rtl/snn_axi_pkg.sv
// Shared AXI4-Lite constants and the weight-loader state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A 16-bit weight occupies the low half of the 32-bit data bus.
    localparam logic [3:0] WSTRB_LO16  = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ADDR,
        ST_RESP,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/synapse_weight_loader.sv
// Streams 16-bit synaptic weights into the weight memory, one AXI4-Lite write per weight.
// Latency: weight accepted at cycle N drives AW/W valid at N+1; done pulses one cycle after the last B handshake.
// Backpressure: one write in flight; w_ready is held low from weight accept until that write's response returns.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_base/cmd_count give first index and word count
//   cmd_error                     one-cycle pulse when a command would run past the end of the memory
//   w_valid/w_ready/w_data        signed weight stream
//   m_axi_aw*/w*/b*               AXI4-Lite write channels toward the weight memory
//   busy, done                    activity level and end-of-command pulse
//   err_count, first_err_idx      per-command failed-write count (saturating) and index of the first failure
module synapse_weight_loader
    import snn_axi_pkg::*;
#(
    parameter int NUM_SYNAPSES = 72865,
    parameter int IDX_W        = $clog2(NUM_SYNAPSES),
    parameter int CNT_W        = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [IDX_W-1:0] cmd_base,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_error,

    input  logic             w_valid,
    output logic             w_ready,
    input  logic [15:0]      w_data,

    output logic [31:0]      m_axi_awaddr,
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    output logic [31:0]      m_axi_wdata,
    output logic [3:0]       m_axi_wstrb,
    output logic             m_axi_wvalid,
    input  logic             m_axi_wready,
    input  logic [1:0]       m_axi_bresp,
    input  logic             m_axi_bvalid,
    output logic             m_axi_bready,

    output logic             busy,
    output logic             done,
    output logic [15:0]      err_count,
    output logic [IDX_W-1:0] first_err_idx
);

    // Range check is done one bit wider than the count so base+count cannot wrap.
    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(NUM_SYNAPSES);

    loader_state_t    r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_rem;
    logic             r_cmd_ready;
    logic             r_cmd_error;
    logic             r_w_ready;
    logic [31:0]      r_awaddr;
    logic             r_awvalid;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_wvalid;
    logic             r_bready;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_err_count;
    logic [IDX_W-1:0] r_first_err_idx;

    logic [CNT_W:0]   w_sum;
    logic             w_aw_done;
    logic             w_w_done;

    assign w_sum = (CNT_W+1)'(cmd_base) + (CNT_W+1)'(cmd_count);

    // A channel counts as finished once its valid has dropped or is handshaking this cycle,
    // so AW and W may complete in either order or together.
    assign w_aw_done = !r_awvalid || m_axi_awready;
    assign w_w_done  = !r_wvalid  || m_axi_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_idx           <= '0;
            r_rem           <= '0;
            r_cmd_ready     <= 1'b1;
            r_cmd_error     <= 1'b0;
            r_w_ready       <= 1'b0;
            r_awaddr        <= '0;
            r_awvalid       <= 1'b0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_wvalid        <= 1'b0;
            r_bready        <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
        end else begin
            r_done      <= 1'b0;
            r_cmd_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (w_sum > LIMIT) begin
                            r_cmd_error <= 1'b1;
                        end else if (cmd_count == '0) begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_idx           <= cmd_base;
                            r_rem           <= cmd_count;
                            r_err_count     <= '0;
                            r_first_err_idx <= '0;
                            r_w_ready       <= 1'b1;
                            r_cmd_ready     <= 1'b0;
                            r_busy          <= 1'b1;
                            r_state         <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_valid) begin
                        r_w_ready <= 1'b0;
                        r_awaddr  <= 32'({r_idx, 2'b00});
                        r_wdata   <= {16'b0, w_data};
                        r_wstrb   <= WSTRB_LO16;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid  && m_axi_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        // A failed write is counted and remembered but never stops the command.
                        if (m_axi_bresp != RESP_OKAY) begin
                            if (r_err_count == '0)      r_first_err_idx <= r_idx;
                            if (r_err_count != 16'hFFFF) r_err_count    <= r_err_count + 16'd1;
                        end
                        r_idx <= r_idx + IDX_W'(1);
                        r_rem <= r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_w_ready <= 1'b1;
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign cmd_error     = r_cmd_error;
    assign w_ready       = r_w_ready;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

endmodule
